// File: rtl/execute_stage_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_mdu_if
// Description : E-stage inputs and registered E->M outputs of the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface execute_stage_mdu_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              in_valid;
  logic              FlushE;
  logic              RegWriteE;
  logic              MemToRegE;
  logic              MemWriteE;
  logic [3:0]        ALUControlE;
  logic              ALUSrcE;
  logic              RegDstE;
  logic [REG_W-1:0]  RtE;
  logic [REG_W-1:0]  RdE;
  logic [DATA_W-1:0] value1;
  logic [DATA_W-1:0] value2;
  logic [DATA_W-1:0] SignImmE;
  logic [1:0]        ForwardAE;
  logic [1:0]        ForwardBE;
  logic [DATA_W-1:0] ResultW;

  logic              stallE;
  logic              validM;
  logic              RegWriteM;
  logic              MemToRegM;
  logic              MemWriteM;
  logic [DATA_W-1:0] AluOutM;
  logic [DATA_W-1:0] WriteDataM;
  logic [REG_W-1:0]  WriteRegM;

  modport master (
    output in_valid, FlushE, RegWriteE, MemToRegE, MemWriteE, ALUControlE,
           ALUSrcE, RegDstE, RtE, RdE, value1, value2, SignImmE,
           ForwardAE, ForwardBE, ResultW,
    input  stallE, validM, RegWriteM, MemToRegM, MemWriteM, AluOutM,
           WriteDataM, WriteRegM
  );

  modport slave (
    input  in_valid, FlushE, RegWriteE, MemToRegE, MemWriteE, ALUControlE,
           ALUSrcE, RegDstE, RtE, RdE, value1, value2, SignImmE,
           ForwardAE, ForwardBE, ResultW,
    output stallE, validM, RegWriteM, MemToRegM, MemWriteM, AluOutM,
           WriteDataM, WriteRegM
  );
endinterface
`default_nettype wire

// File: rtl/execute_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module      : execute_stage_mdu
// Description : Execute stage with forwarding, ALU, iterative MULTU/DIVU with
//               HI/LO, stall/flush handling and the registered E->M boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_stage_mdu #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  wire logic          clk,
  input  wire logic          reset,
  execute_stage_mdu_if.slave bus
);

  localparam int         c_CNT_W    = $clog2(DATA_W);
  localparam logic [3:0] c_OP_AND   = 4'b0000;
  localparam logic [3:0] c_OP_OR    = 4'b0001;
  localparam logic [3:0] c_OP_ADD   = 4'b0010;
  localparam logic [3:0] c_OP_XOR   = 4'b0011;
  localparam logic [3:0] c_OP_SUB   = 4'b0110;
  localparam logic [3:0] c_OP_SLT   = 4'b0111;
  localparam logic [3:0] c_OP_MULTU = 4'b1000;
  localparam logic [3:0] c_OP_DIVU  = 4'b1001;
  localparam logic [3:0] c_OP_MFHI  = 4'b1010;
  localparam logic [3:0] c_OP_MFLO  = 4'b1011;
  localparam logic [3:0] c_OP_NOR   = 4'b1100;
  localparam logic [3:0] c_OP_LUI   = 4'b1111;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_stateNext;
  logic [c_CNT_W-1:0]  r_count;
  logic [c_CNT_W-1:0]  w_countNext;

  logic [DATA_W-1:0]   w_srcA;
  logic [DATA_W-1:0]   w_fwdB;
  logic [DATA_W-1:0]   w_srcB;
  logic [REG_W-1:0]    w_writeReg;
  logic [DATA_W-1:0]   w_aluResult;
  logic                w_isMdu;

  logic [DATA_W-1:0]   r_accHi;
  logic [DATA_W-1:0]   r_accLo;
  logic [DATA_W-1:0]   r_mcand;
  logic                r_isDiv;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;

  logic [DATA_W:0]     w_mulSum;
  logic [DATA_W:0]     w_divShift;
  logic [DATA_W:0]     w_divDiff;
  logic                w_divFits;
  logic [DATA_W-1:0]   w_iterHi;
  logic [DATA_W-1:0]   w_iterLo;

  logic                w_load;
  logic                w_iterate;
  logic                w_hiloWe;
  logic                w_stall;
  logic                w_captureM;

  logic                r_validM;
  logic                r_regWriteM;
  logic                r_memToRegM;
  logic                r_memWriteM;
  logic [DATA_W-1:0]   r_aluOutM;
  logic [DATA_W-1:0]   r_writeDataM;
  logic [REG_W-1:0]    r_writeRegM;

  // Operand forwarding; AluOutM comes from the M register so back-to-back
  // dependent instructions need no stall.
  always_comb begin
    case (bus.ForwardAE)
      2'b01:   w_srcA = bus.ResultW;
      2'b10:   w_srcA = r_aluOutM;
      default: w_srcA = bus.value1;
    endcase
    case (bus.ForwardBE)
      2'b01:   w_fwdB = bus.ResultW;
      2'b10:   w_fwdB = r_aluOutM;
      default: w_fwdB = bus.value2;
    endcase
  end

  assign w_srcB     = bus.ALUSrcE ? bus.SignImmE : w_fwdB;
  assign w_writeReg = bus.RegDstE ? bus.RdE : bus.RtE;
  assign w_isMdu    = (bus.ALUControlE == c_OP_MULTU) || (bus.ALUControlE == c_OP_DIVU);

  always_comb begin
    w_aluResult = '0;
    case (bus.ALUControlE)
      c_OP_AND:  w_aluResult = w_srcA & w_srcB;
      c_OP_OR:   w_aluResult = w_srcA | w_srcB;
      c_OP_XOR:  w_aluResult = w_srcA ^ w_srcB;
      c_OP_NOR:  w_aluResult = ~(w_srcA | w_srcB);
      c_OP_ADD:  w_aluResult = w_srcA + w_srcB;
      c_OP_SUB:  w_aluResult = w_srcA - w_srcB;
      c_OP_SLT:  w_aluResult = {{(DATA_W-1){1'b0}}, ($signed(w_srcA) < $signed(w_srcB))};
      c_OP_LUI:  w_aluResult = w_srcB << (DATA_W/2);
      c_OP_MFHI: w_aluResult = r_hi;
      c_OP_MFLO: w_aluResult = r_lo;
      default:   w_aluResult = '0;
    endcase
  end

  // Shared iteration datapath. MULTU: accHi accumulates, accLo holds the
  // multiplier and receives product bits. DIVU: accHi is the partial
  // remainder, accLo shifts dividend bits out and quotient bits in.
  assign w_mulSum   = {1'b0, r_accHi} + {1'b0, (r_accLo[0] ? r_mcand : {DATA_W{1'b0}})};
  assign w_divShift = {r_accHi, r_accLo[DATA_W-1]};
  assign w_divDiff  = w_divShift - {1'b0, r_mcand};
  assign w_divFits  = ~w_divDiff[DATA_W];

  always_comb begin
    if (r_isDiv) begin
      w_iterHi = w_divFits ? w_divDiff[DATA_W-1:0] : w_divShift[DATA_W-1:0];
      w_iterLo = {r_accLo[DATA_W-2:0], w_divFits};
    end else begin
      w_iterHi = w_mulSum[DATA_W:1];
      w_iterLo = {w_mulSum[0], r_accLo[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_stateNext;
      r_count <= w_countNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_countNext = r_count;
    w_load      = 1'b0;
    w_iterate   = 1'b0;
    w_hiloWe    = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.in_valid && w_isMdu && !bus.FlushE) begin
          w_stateNext = BUSY;
          w_countNext = c_CNT_W'(DATA_W - 1);
          w_load      = 1'b1;
          w_stall     = 1'b1;
        end
      end
      BUSY: begin
        if (bus.FlushE) begin
          w_stateNext = IDLE;
          w_countNext = '0;
        end else if (r_count != '0) begin
          w_countNext = r_count - 1'b1;
          w_iterate   = 1'b1;
          w_stall     = 1'b1;
        end else begin
          w_stateNext = IDLE;
          w_iterate   = 1'b1;
          w_hiloWe    = 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_countNext = '0;
      end
    endcase
  end

  // The multiplicand/divisor and op kind are latched at issue, so the
  // operation is immune to input changes while it runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_accHi <= '0;
      r_accLo <= '0;
      r_mcand <= '0;
      r_isDiv <= 1'b0;
    end else if (w_load) begin
      r_accHi <= '0;
      r_accLo <= (bus.ALUControlE == c_OP_DIVU) ? w_srcA : w_fwdB;
      r_mcand <= (bus.ALUControlE == c_OP_DIVU) ? w_fwdB : w_srcA;
      r_isDiv <= (bus.ALUControlE == c_OP_DIVU);
    end else if (w_iterate) begin
      r_accHi <= w_iterHi;
      r_accLo <= w_iterLo;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_hiloWe) begin
      r_hi <= w_iterHi;
      r_lo <= w_iterLo;
    end
  end

  assign w_captureM = bus.in_valid && !bus.FlushE && !w_stall;

  // Bubbles clear the valid/control bits but leave the data fields as-is.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_validM     <= 1'b0;
      r_regWriteM  <= 1'b0;
      r_memToRegM  <= 1'b0;
      r_memWriteM  <= 1'b0;
      r_aluOutM    <= '0;
      r_writeDataM <= '0;
      r_writeRegM  <= '0;
    end else if (w_captureM) begin
      r_validM     <= 1'b1;
      r_regWriteM  <= bus.RegWriteE && !w_isMdu;
      r_memToRegM  <= bus.MemToRegE;
      r_memWriteM  <= bus.MemWriteE && !w_isMdu;
      r_aluOutM    <= w_aluResult;
      r_writeDataM <= w_fwdB;
      r_writeRegM  <= w_writeReg;
    end else begin
      r_validM     <= 1'b0;
      r_regWriteM  <= 1'b0;
      r_memToRegM  <= 1'b0;
      r_memWriteM  <= 1'b0;
    end
  end

  assign bus.stallE     = w_stall && !reset;
  assign bus.validM     = r_validM;
  assign bus.RegWriteM  = r_regWriteM;
  assign bus.MemToRegM  = r_memToRegM;
  assign bus.MemWriteM  = r_memWriteM;
  assign bus.AluOutM    = r_aluOutM;
  assign bus.WriteDataM = r_writeDataM;
  assign bus.WriteRegM  = r_writeRegM;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_stage_mdu
// Description : Table vectors, hand sequences and random stimulus for the
//               execute stage, checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage_mdu;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  execute_stage_mdu_if #(.DATA_W(DATA_W), .REG_W(REG_W)) bus ();

  execute_stage_mdu #(.DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] v1, v2, imm;
    logic [1:0]  fa, fb;
    logic        src, dst;
    logic [4:0]  rt, rd;
    logic [31:0] resW;
    logic        rw, mtr, mw;
    logic        chk;
    logic [31:0] expAlu, expWd;
    logic [4:0]  expWr;
  } vec_t;

  int          tests;
  int          fails;
  logic [31:0] mHi, mLo, mAlu;
  bit          aluKnown;
  vec_t        tbl [25];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] sel, input logic [31:0] rf,
                                      input logic [31:0] resW);
    if (sel == 2'b01) return resW;
    if (sel == 2'b10) return mAlu;
    return rf;
  endfunction

  function automatic vec_t modelVec(input vec_t v);
    logic [31:0] a, b, s;
    a = fwd(v.fa, v.v1, v.resW);
    b = fwd(v.fb, v.v2, v.resW);
    s = v.src ? v.imm : b;
    case (v.op)
      4'b0000: v.expAlu = a & s;
      4'b0001: v.expAlu = a | s;
      4'b0011: v.expAlu = a ^ s;
      4'b1100: v.expAlu = ~(a | s);
      4'b0010: v.expAlu = a + s;
      4'b0110: v.expAlu = a - s;
      4'b0111: v.expAlu = ($signed(a) < $signed(s)) ? 32'd1 : 32'd0;
      4'b1111: v.expAlu = s * 32'h10000;
      4'b1010: v.expAlu = mHi;
      4'b1011: v.expAlu = mLo;
      default: v.expAlu = 32'd0;
    endcase
    v.expWd = b;
    v.expWr = v.dst ? v.rd : v.rt;
    v.chk   = !(v.op == 4'b1000 || v.op == 4'b1001);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.in_valid    = 1'b1;
    bus.FlushE      = 1'b0;
    bus.ALUControlE = v.op;
    bus.value1      = v.v1;
    bus.value2      = v.v2;
    bus.SignImmE    = v.imm;
    bus.ForwardAE   = v.fa;
    bus.ForwardBE   = v.fb;
    bus.ALUSrcE     = v.src;
    bus.RegDstE     = v.dst;
    bus.RtE         = v.rt;
    bus.RdE         = v.rd;
    bus.ResultW     = v.resW;
    bus.RegWriteE   = v.rw;
    bus.MemToRegE   = v.mtr;
    bus.MemWriteE   = v.mw;
  endtask

  task automatic idleIn();
    vec_t z;
    z = '{4'h0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd0, 5'd0, 32'd0,
          1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    drive(z);
    bus.in_valid = 1'b0;
  endtask

  task automatic checkAllZero(input string nm);
    chk({nm, "/validM"},     64'(bus.validM),     64'd0);
    chk({nm, "/RegWriteM"},  64'(bus.RegWriteM),  64'd0);
    chk({nm, "/MemToRegM"},  64'(bus.MemToRegM),  64'd0);
    chk({nm, "/MemWriteM"},  64'(bus.MemWriteM),  64'd0);
    chk({nm, "/AluOutM"},    64'(bus.AluOutM),    64'd0);
    chk({nm, "/WriteDataM"}, 64'(bus.WriteDataM), 64'd0);
    chk({nm, "/WriteRegM"},  64'(bus.WriteRegM),  64'd0);
    chk({nm, "/stallE"},     64'(bus.stallE),     64'd0);
  endtask

  // Present one instruction, count stall cycles, then check the M outputs.
  task automatic runOp(input vec_t v, input string nm);
    bit          isMdu;
    int          cnt;
    logic [31:0] a, b;
    logic [63:0] p;
    isMdu = (v.op == 4'b1000 || v.op == 4'b1001);
    a = fwd(v.fa, v.v1, v.resW);
    b = fwd(v.fb, v.v2, v.resW);
    drive(v);
    #1;
    cnt = 0;
    while (bus.stallE === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk);
      #1;
    end
    chk({nm, "/stall"}, 64'(cnt), isMdu ? 64'(DATA_W) : 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "/validM"},     64'(bus.validM),     64'd1);
    chk({nm, "/RegWriteM"},  64'(bus.RegWriteM),  64'(v.rw && !isMdu));
    chk({nm, "/MemToRegM"},  64'(bus.MemToRegM),  64'(v.mtr));
    chk({nm, "/MemWriteM"},  64'(bus.MemWriteM),  64'(v.mw && !isMdu));
    chk({nm, "/WriteDataM"}, 64'(bus.WriteDataM), 64'(v.expWd));
    chk({nm, "/WriteRegM"},  64'(bus.WriteRegM),  64'(v.expWr));
    if (v.chk) chk({nm, "/AluOutM"}, 64'(bus.AluOutM), 64'(v.expAlu));
    if (isMdu) begin
      if (v.op == 4'b1000) begin
        p   = {32'd0, a} * {32'd0, b};
        mHi = p[63:32];
        mLo = p[31:0];
      end else if (b == 32'd0) begin
        mLo = 32'hFFFF_FFFF;
        mHi = a;
      end else begin
        mLo = a / b;
        mHi = a % b;
      end
      aluKnown = 1'b0;
    end else begin
      mAlu     = v.expAlu;
      aluKnown = 1'b1;
    end
  endtask

  function automatic vec_t randVec();
    logic [3:0] opList [14];
    vec_t v;
    opList = '{4'h0, 4'h1, 4'h3, 4'hC, 4'h2, 4'h6, 4'h7, 4'hF, 4'hA, 4'hB,
               4'h8, 4'h9, 4'h4, 4'hD};
    v.op   = opList[$urandom_range(0, 13)];
    v.v1   = $urandom;
    v.v2   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
    v.imm  = $urandom;
    v.fa   = 2'($urandom_range(0, 3));
    v.fb   = 2'($urandom_range(0, 3));
    if (!aluKnown && v.fa == 2'b10) v.fa = 2'b00;
    if (!aluKnown && v.fb == 2'b10) v.fb = 2'b00;
    v.src  = 1'($urandom_range(0, 1));
    v.dst  = 1'($urandom_range(0, 1));
    v.rt   = 5'($urandom);
    v.rd   = 5'($urandom);
    v.resW = $urandom;
    v.rw   = 1'($urandom_range(0, 1));
    v.mtr  = 1'($urandom_range(0, 1));
    v.mw   = 1'($urandom_range(0, 1));
    return modelVec(v);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   k;
    tests = 0; fails = 0;
    mHi = 0; mLo = 0; mAlu = 0; aluKnown = 1'b1;
    reset = 1'b1;
    idleIn();

    // op, v1, v2, imm, fa, fb, src, dst, rt, rd, resW, rw, mtr, mw, chk, expAlu, expWd, expWr
    tbl[0]  = '{4'h2, 32'd10, 32'd12, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd22, 32'd12, 5'd3};
    tbl[1]  = '{4'h2, 32'd10, 32'd12, 32'd0, 2'd2, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd34, 32'd12, 5'd3};
    tbl[2]  = '{4'h6, 32'd10, 32'd12, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd12, 5'd3};
    tbl[3]  = '{4'h7, 32'd10, 32'd12, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 32'd12, 5'd3};
    tbl[4]  = '{4'h2, 32'd10, 32'd12, 32'd0, 2'd0, 2'd1, 1'b0, 1'b1, 5'd7, 5'd3, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'd15, 32'd5, 5'd3};
    tbl[5]  = '{4'h8, 32'hFFFF_FFFF, 32'd2, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 32'd2, 5'd7};
    tbl[6]  = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 32'd0, 5'd9};
    tbl[7]  = '{4'hB, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 32'd0, 5'd9};
    tbl[8]  = '{4'h9, 32'd100, 32'd7, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd4, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd7, 5'd4};
    tbl[9]  = '{4'hB, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd14, 32'd0, 5'd9};
    tbl[10] = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'd0, 5'd9};
    tbl[11] = '{4'h9, 32'd9, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd4, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd4};
    tbl[12] = '{4'hB, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd0, 5'd9};
    tbl[13] = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd9, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd9, 32'd0, 5'd9};
    tbl[14] = '{4'hF, 32'd0, 32'hABCD, 32'h1234, 2'd0, 2'd0, 1'b1, 1'b1, 5'd7, 5'd12, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1234_0000, 32'hABCD, 5'd12};
    tbl[15] = '{4'hC, 32'hF0F0_F0F0, 32'h0F0F_00FF, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0F00, 32'h0F0F_00FF, 5'd3};
    tbl[16] = '{4'h3, 32'hF0F0_F0F0, 32'h0F0F_00FF, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_F00F, 32'h0F0F_00FF, 5'd3};
    tbl[17] = '{4'h0, 32'h1234_5678, 32'h55, 32'hFFFF_8000, 2'd0, 2'd0, 1'b1, 1'b0, 5'd21, 5'd3, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1234_0000, 32'h55, 5'd21};
    tbl[18] = '{4'h1, 32'h00FF_0000, 32'hFF, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00FF_00FF, 32'hFF, 5'd3};
    tbl[19] = '{4'h4, 32'd5, 32'd6, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 32'd6, 5'd3};
    tbl[20] = '{4'h7, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 32'd1, 5'd3};
    tbl[21] = '{4'h2, 32'hFFFF_FFFF, 32'd2, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 32'd2, 5'd3};
    tbl[22] = '{4'h2, 32'd3, 32'd4, 32'd0, 2'd3, 2'd3, 1'b0, 1'b1, 5'd7, 5'd3, 32'd99, 1'b1, 1'b0, 1'b0, 1'b1, 32'd7, 32'd4, 5'd3};
    tbl[23] = '{4'h2, 32'd1, 32'd5, 32'd0, 2'd1, 2'd0, 1'b0, 1'b1, 5'd7, 5'd3, 32'd100, 1'b1, 1'b0, 1'b0, 1'b1, 32'd105, 32'd5, 5'd3};
    tbl[24] = '{4'h6, 32'd200, 32'd0, 32'd0, 2'd0, 2'd2, 1'b0, 1'b1, 5'd7, 5'd3, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd95, 32'd105, 5'd3};

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    reset = 1'b0;

    for (int i = 0; i < 25; i++) runOp(tbl[i], $sformatf("vec%0d", i));

    // Flush on BUSY cycle 10 of a MULTU: HI/LO must keep their old contents.
    v = '{4'h8, 32'h1234, 32'h5678, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd1, 5'd2, 32'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    drive(v);
    #1;
    chk("flush/stallIssue", 64'(bus.stallE), 64'd1);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("flush/stallBusy10", 64'(bus.stallE), 64'd1);
    bus.FlushE = 1'b1;
    #1;
    chk("flush/stallDrop", 64'(bus.stallE), 64'd0);
    @(posedge clk);
    #1;
    chk("flush/validM", 64'(bus.validM), 64'd0);
    chk("flush/RegWriteM", 64'(bus.RegWriteM), 64'd0);
    v = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd0, 5'd8, 32'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    runOp(modelVec(v), "flush/mfhi");
    v.op = 4'hB;
    runOp(modelVec(v), "flush/mflo");

    // Random instructions, bubbles and flushes against the reference model.
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      v = randVec();
      if (k == 0) begin
        drive(v);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("rnd/bubbleValid", 64'(bus.validM), 64'd0);
        chk("rnd/bubbleRegWrite", 64'(bus.RegWriteM), 64'd0);
        if (aluKnown) chk("rnd/bubbleHold", 64'(bus.AluOutM), 64'(mAlu));
      end else if (k == 1) begin
        drive(v);
        bus.FlushE = 1'b1;
        #1;
        chk("rnd/flushStall", 64'(bus.stallE), 64'd0);
        @(posedge clk);
        #1;
        chk("rnd/flushValid", 64'(bus.validM), 64'd0);
        chk("rnd/flushMemWrite", 64'(bus.MemWriteM), 64'd0);
      end else begin
        runOp(v, $sformatf("rnd%0d_op%0h", n, v.op));
      end
    end

    // Reset in the middle of a DIVU aborts it and clears HI/LO.
    v = '{4'h9, 32'd1000, 32'd3, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd6, 5'd2, 32'd0,
          1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 5'd0};
    drive(v);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    checkAllZero("midReset");
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mHi = 0; mLo = 0; mAlu = 0; aluKnown = 1'b1;
    v = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd0, 5'd8, 32'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    runOp(modelVec(v), "postReset/mfhi");
    v.op = 4'hB;
    runOp(modelVec(v), "postReset/mflo");
    v = '{4'h8, 32'hDEAD_BEEF, 32'h0000_1001, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0, 5'd6, 5'd2, 32'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    runOp(modelVec(v), "postReset/multu");
    v = '{4'hA, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1, 5'd0, 5'd8, 32'd0,
          1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0};
    runOp(modelVec(v), "postReset/mfhi2");

    idleIn();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
